// File: rtl/ram_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ram_cmd_master                                               |
// | Description : Host-side initiator turning single read/write requests into  |
// |               the 10-bit din/rx_valid RAM command sequence and collecting  |
// |               read data from dout/tx_valid. Define ADDR_CACHE_EN to skip   |
// |               address commands that repeat the last issued address.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_cmd_master #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic [9:0] din,
    output logic       rx_valid,
    input  logic [7:0] dout,
    input  logic       tx_valid
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WR_ADDR  = 3'd1;
    localparam logic [2:0] c_WR_DATA  = 3'd2;
    localparam logic [2:0] c_RD_ADDR  = 3'd3;
    localparam logic [2:0] c_RD_FETCH = 3'd4;
    localparam logic [2:0] c_RD_WAIT  = 3'd5;
    localparam logic [2:0] c_RSP      = 3'd6;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_cnt;
    logic       w_timeout;
    logic       w_wr_hit;
    logic       w_rd_hit;
    logic [7:0] w_addr;
    logic [7:0] w_wdata;

    logic [9:0] r_din;
    logic       r_rx_valid;
    logic       r_rsp_valid;
    logic       r_rsp_err;
    logic [7:0] r_rsp_rdata;

    logic [9:0] w_din_nxt;
    logic       w_rx_valid_nxt;
    logic       w_rsp_valid_nxt;
    logic       w_rsp_err_nxt;
    logic [7:0] w_rsp_rdata_nxt;

    // The first command word is registered on the accept edge, so it must
    // come straight from the request rather than the latched copy.
    assign w_addr  = (r_state == c_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;

    assign req_ready = (r_state == c_IDLE);
    assign din       = r_din;
    assign rx_valid  = r_rx_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

`ifdef ADDR_CACHE_EN
    logic       r_lw_valid;
    logic       r_lr_valid;
    logic [7:0] r_lw_addr;
    logic [7:0] r_lr_addr;

    assign w_wr_hit = r_lw_valid && (r_lw_addr == req_addr);
    assign w_rd_hit = r_lr_valid && (r_lr_addr == req_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lw_valid <= 1'b0;
            r_lr_valid <= 1'b0;
            r_lw_addr  <= 8'h00;
            r_lr_addr  <= 8'h00;
        end else begin
            if (w_state_nxt == c_WR_ADDR) begin
                r_lw_valid <= 1'b1;
                r_lw_addr  <= w_addr;
            end
            if (w_state_nxt == c_RD_ADDR) begin
                r_lr_valid <= 1'b1;
                r_lr_addr  <= w_addr;
            end else if (w_timeout) begin
                r_lr_valid <= 1'b0;
            end
        end
    end
`else
    assign w_wr_hit = 1'b0;
    assign w_rd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_cnt       <= 8'h00;
            r_din       <= 10'h000;
            r_rx_valid  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_din       <= w_din_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            if (r_state == c_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_cnt <= (r_state == c_RD_WAIT && w_state_nxt == c_RD_WAIT) ? r_cnt + 8'd1 : 8'h00;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        w_state_nxt = w_wr_hit ? c_WR_DATA : c_WR_ADDR;
                    end else begin
                        w_state_nxt = w_rd_hit ? c_RD_FETCH : c_RD_ADDR;
                    end
                end
            end
            c_WR_ADDR:  w_state_nxt = c_WR_DATA;
            c_WR_DATA:  w_state_nxt = c_RSP;
            c_RD_ADDR:  w_state_nxt = c_RD_FETCH;
            c_RD_FETCH: w_state_nxt = c_RD_WAIT;
            c_RD_WAIT: begin
                // Data arriving on the final count still wins over the timeout.
                if (tx_valid) begin
                    w_state_nxt = c_RSP;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = c_RSP;
                    w_timeout   = 1'b1;
                end
            end
            c_RSP:      w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_din_nxt       = 10'h000;
        w_rx_valid_nxt  = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 8'h00;
        case (w_state_nxt)
            c_WR_ADDR: begin
                w_rx_valid_nxt = 1'b1;
                w_din_nxt      = {2'b00, w_addr};
            end
            c_WR_DATA: begin
                w_rx_valid_nxt = 1'b1;
                w_din_nxt      = {2'b01, w_wdata};
            end
            c_RD_ADDR: begin
                w_rx_valid_nxt = 1'b1;
                w_din_nxt      = {2'b10, w_addr};
            end
            c_RD_FETCH: begin
                w_rx_valid_nxt = 1'b1;
                w_din_nxt      = {2'b11, 8'h00};
            end
            c_RSP: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = w_timeout;
                if (r_state == c_RD_WAIT && tx_valid) begin
                    w_rsp_rdata_nxt = dout;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_cmd_master                                            |
// | Description : Randomized scoreboard bench for ram_cmd_master with an       |
// |               attached RAM model; honours ADDR_CACHE_EN when defined.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ram_cmd_master;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    ram_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .din       (din),
        .rx_valid  (rx_valid),
        .dout      (dout),
        .tx_valid  (tx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         acc;
        int         lat;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [9:0] exp_cmd[$];

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         lw_v = 0;
    bit         lr_v = 0;
    logic [7:0] lw_a = 8'h00;
    logic [7:0] lr_a = 8'h00;

    // RAM environment state
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa = 8'h00;
    logic [7:0] ram_ra = 8'h00;
    int         ram_delay = 0;
    int         pend = 0;
    logic [7:0] pend_data = 8'h00;
    int         stray_req = 0;
    int         stray_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // RAM model: latches addresses, stores writes, answers a fetch after ram_delay cycles
    initial begin : ram_model
        tx_valid = 1'b0;
        dout     = 8'h00;
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
        forever begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tx_valid = 1'b1;
                    dout     = pend_data;
                end
            end else if (stray_req != stray_done) begin
                stray_done++;
                tx_valid = 1'b1;
                dout     = 8'($urandom);
            end
            if (rx_valid && !rst) begin
                case (din[9:8])
                    2'b00: ram_wa = din[7:0];
                    2'b01: ram_mem[ram_wa] = din[7:0];
                    2'b10: ram_ra = din[7:0];
                    default: begin
                        if (ram_delay > 0) begin
                            pend      = ram_delay;
                            pend_data = ram_mem[ram_ra];
                        end
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        bit         chk_rdy;
        rsp_t       r;
        logic [9:0] c;
        chk_rdy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_rdy = 0;
            end else begin
                if (chk_rdy) begin
                    check("req_ready_after_rsp", 32'(req_ready), 32'd1);
                    chk_rdy = 0;
                end
                if (rx_valid) begin
                    if (exp_cmd.size() == 0) begin
                        unexpected("din", 32'(din));
                    end else begin
                        c = exp_cmd.pop_front();
                        check("din", 32'(din), 32'(c));
                    end
                end
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        unexpected("rsp_valid", 32'(rsp_rdata));
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_err", 32'(rsp_err), 32'(r.err));
                        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                        check("latency", 32'(cyc - r.acc), 32'(r.lat));
                        chk_rdy = 1;
                    end
                end
            end
        end
    end

    task automatic model_push(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input int delay, input int acc);
        rsp_t r;
        bit   skip;
        int   base;
        skip  = 0;
        r.acc = acc;
        if (we) begin
`ifdef ADDR_CACHE_EN
            skip = lw_v && (lw_a == addr);
            lw_v = 1;
            lw_a = addr;
`endif
            if (!skip) exp_cmd.push_back({2'b00, addr});
            exp_cmd.push_back({2'b01, wdata});
            ref_mem[addr] = wdata;
            r.err   = 1'b0;
            r.rdata = 8'h00;
            r.lat   = skip ? 2 : 3;
        end else begin
`ifdef ADDR_CACHE_EN
            skip = lr_v && (lr_a == addr);
            lr_v = 1;
            lr_a = addr;
`endif
            if (!skip) exp_cmd.push_back({2'b10, addr});
            exp_cmd.push_back(10'h300);
            base = skip ? 2 : 3;
            if (delay >= 1 && delay <= TIMEOUT) begin
                r.err   = 1'b0;
                r.rdata = ref_mem[addr];
                r.lat   = base + delay;
            end else begin
                r.err   = 1'b1;
                r.rdata = 8'h00;
                r.lat   = base + TIMEOUT;
                lr_v    = 0;
            end
        end
        exp_rsp.push_back(r);
    endtask

    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int delay, input bit hold);
        int waitc;
        waitc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            unexpected("accept_timeout", 32'(addr));
            req_valid = 1'b0;
        end else begin
            ram_delay = delay;
            model_push(we, addr, wdata, delay, cyc);
            @(posedge clk);
            if (!hold) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_rsp.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_rsp.delete();
        exp_cmd.delete();
        lw_v = 0;
        lr_v = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic       we;
        logic [7:0] addr;
        int         delay;
        bit         hold;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        #12;
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_din", 32'(din), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;

        // Directed: write, read-back, timeout
        issue(1'b1, 8'h12, 8'h3C, 0, 0);
        wait_idle();
        issue(1'b0, 8'h12, 8'h00, 2, 0);
        wait_idle();
        issue(1'b0, 8'h12, 8'h00, 0, 0);
        wait_idle();
        issue(1'b0, 8'h12, 8'h00, TIMEOUT, 0);
        wait_idle();
        issue(1'b0, 8'h13, 8'h00, 1, 0);
        wait_idle();

        // Reset while waiting for read data
        issue(1'b0, 8'h77, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(1'b0, 8'hFF, 8'h00, 2, 0);
        wait_idle();

        // Back-to-back with req_valid held, then a stray tx_valid while idle
        issue(1'b1, 8'h01, 8'hAA, 0, 1);
        issue(1'b0, 8'h01, 8'h00, 2, 0);
        wait_idle();
        stray_req++;
        repeat (4) @(negedge clk);

        // Repeated and neighbouring addresses exercise the address cache
        issue(1'b1, 8'h40, 8'h11, 0, 0);
        issue(1'b1, 8'h40, 8'h22, 0, 0);
        issue(1'b1, 8'h41, 8'h33, 0, 0);
        issue(1'b0, 8'h41, 8'h00, 2, 0);
        issue(1'b0, 8'h41, 8'h00, 3, 0);
        wait_idle();

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       addr = 8'hFF;
                1:       addr = 8'h40 + 8'($urandom_range(0, 1));
                default: addr = 8'($urandom);
            endcase
            delay = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            hold  = (n != 79) && ($urandom_range(0, 1) == 1);
            issue(we, addr, 8'($urandom), delay, hold);
            if (!hold && $urandom_range(0, 3) == 0) begin
                wait_idle();
                stray_req++;
                repeat (3) @(negedge clk);
            end
        end
        wait_idle();
        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
